// File: rtl/ser_demux_pkg.sv
// rtl/ser_demux_pkg.sv - shared types, sizing helper and seven-segment patterns for ser_demux_n
package ser_demux_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, DONE} state_e;

   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // gfedcba, active-high, hex digits 0..F
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex digit to seven-segment (gfedcba, active-high) decoder
module seg7_decoder
   import ser_demux_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/ser_demux_n.sv
// rtl/ser_demux_n.sv - serial frame demux: start bit, channel address, length, payload routed to one channel
// Defining SER_DEMUX_SSD_EN adds SSD_Out, a seven-segment decode of ChSel.
module ser_demux_n
   import ser_demux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int LEN_W  = 4,
   localparam int ADDR_W = clog2_min1(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clkEn,
   input  logic              SerIn,
   output logic [NUM_CH-1:0] SerOut,
   output logic              SerOutValid,
   output logic              Done,
   output logic              Err,
   output logic              Busy,
   output logic [ADDR_W-1:0] ChSel
`ifdef SER_DEMUX_SSD_EN
   ,
   output logic [6:0]        SSD_Out
`endif
);

   localparam int BC_W = clog2_min1(((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1);

   state_e            state_q, state_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] ch_sel_q, ch_sel_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_sh;
   logic [LEN_W-1:0]  len_sh;
   logic              ch_ok;

   assign addr_sh = (addr_q << 1) | ADDR_W'(SerIn);
   assign len_sh  = (cnt_q << 1) | LEN_W'(SerIn);
   // Non-power-of-two channel counts leave unused addresses that must not route
   assign ch_ok   = int'(ch_sel_q) < NUM_CH;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         addr_q    <= '0;
         ch_sel_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         addr_q    <= addr_d;
         ch_sel_q  <= ch_sel_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      addr_d    = addr_q;
      ch_sel_d  = ch_sel_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (clkEn && !SerIn) begin
               state_d   = ADDR;
               bit_cnt_d = '0;
            end
         end
         ADDR: begin
            if (clkEn) begin
               addr_d = addr_sh;
               if (bit_cnt_q == BC_W'(ADDR_W - 1)) begin
                  ch_sel_d  = addr_sh;
                  bit_cnt_d = '0;
                  state_d   = LEN;
               end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end
         end
         LEN: begin
            if (clkEn) begin
               cnt_d = len_sh;
               if (bit_cnt_q == BC_W'(LEN_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (len_sh == '0) ? DONE : DATA;
               end else begin
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end
         end
         DATA: begin
            if (clkEn) begin
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      SerOut      = '0;
      SerOutValid = 1'b0;
      if (state_q == DATA && ch_ok) begin
         SerOutValid = 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_q == ADDR_W'(i)) SerOut[i] = SerIn;
         end
      end
   end

   assign Done  = (state_q == DONE);
   assign Err   = (state_q == DONE) && !ch_ok;
   assign Busy  = (state_q != IDLE);
   assign ChSel = ch_sel_q;

`ifdef SER_DEMUX_SSD_EN
   seg7_decoder u_seg7 (
      .hex_i (4'(ch_sel_q)),
      .seg_o (SSD_Out)
   );
`endif

endmodule
